// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - load/store access-type codes and bridge FSM encodings.
package riscv_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unlisted type codes behave as full words, so they need word alignment.
  function automatic logic lsu_misaligned(input logic [2:0] rw_type, input logic [1:0] addr_lo);
    case (rw_type)
      RW_B, RW_BU: return 1'b0;
      RW_H, RW_HU: return addr_lo[0];
      default:     return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// rtl/lsu_lane_format.sv - store byte-enable/lane replication and load extraction/extension.
module lsu_lane_format
  import riscv_pkg::*;
(
  input  logic [2:0]  st_type_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_type_i)
      RW_B, RW_BU: begin
        st_be_o    = 4'b0001 << st_addr_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      RW_H, RW_HU: begin
        st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_addr_i, 3'b000} +: 8];
  assign ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_type_i)
      RW_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      RW_BU:   ld_data_o = {24'h0, ld_byte};
      RW_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      RW_HU:   ld_data_o = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - core load/store port to handshaked 32-bit data bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse bus_err.
module lsu_bus_bridge
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr,
  input  logic [31:0] Wr_mem_data,
  input  logic        W_en,
  input  logic        R_en,
  input  logic [2:0]  RW_type,
  output logic [31:0] Rd_mem_data,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  lsu_state_e        state_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        type_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic              bus_req_q, bus_we_q, bus_err_q;
  logic [31:0]       bus_addr_q, bus_wdata_q, rd_q;
  logic [3:0]        bus_be_q;

  logic        req_any, misalign, tmo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  lsu_lane_format u_fmt (
    .st_type_i  (RW_type),
    .st_addr_i  (ram_addr[1:0]),
    .st_data_i  (Wr_mem_data),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_type_i  (type_q),
    .ld_addr_i  (addr_lo_q),
    .ld_rdata_i (bus_rdata),
    .ld_data_o  (ld_data)
  );

  assign req_any = R_en | W_en;
  assign tmo     = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = lsu_misaligned(RW_type, ram_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Stall is combinational in IDLE so the core freezes in the request cycle itself.
  assign stall = (state_q == ST_IDLE) ? req_any : (state_q != ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      type_q      <= 3'b000;
      tcnt_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      rd_q        <= 32'h0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            addr_lo_q <= ram_addr[1:0];
            type_q    <= RW_type;
            if (misalign) begin
              bus_err_q <= 1'b1;
              if (!W_en) rd_q <= 32'h0;
              state_q   <= ST_DONE;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= W_en;
              bus_addr_q  <= {ram_addr[31:2], 2'b00};
              bus_wdata_q <= W_en ? st_wdata : 32'h0;
              bus_be_q    <= st_be;
              tcnt_q      <= '0;
              state_q     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= bus_we_q ? ST_DONE : ST_RESP;
          end else if (tmo) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!bus_we_q) rd_q <= 32'h0;
            state_q   <= ST_DONE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus_rvalid) begin
            rd_q    <= ld_data;
            state_q <= ST_DONE;
          end else if (tmo) begin
            bus_err_q <= 1'b1;
            rd_q      <= 32'h0;
            state_q   <= ST_DONE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_be      = bus_be_q;
  assign bus_err     = bus_err_q;
  assign Rd_mem_data = rd_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb/tb_lsu_bus_bridge.sv - scoreboard bench for lsu_bus_bridge with a simple bus slave model.
module tb_lsu_bus_bridge;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ram_addr = 32'h0;
  logic [31:0] Wr_mem_data = 32'h0;
  logic        W_en = 1'b0;
  logic        R_en = 1'b0;
  logic [2:0]  RW_type = 3'b000;
  logic [31:0] Rd_mem_data;
  logic        stall;
  logic        bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(16), .TCNT_W(5)) dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .Wr_mem_data(Wr_mem_data),
    .W_en(W_en), .R_en(R_en), .RW_type(RW_type), .Rd_mem_data(Rd_mem_data),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;
  typedef struct { logic err; logic [31:0] rd; int stalls; } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    slv_gnt_dly = 0;
  int    slv_rv_dly = 0;
  logic [31:0] slv_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.be = be;
    req_q.push_back(r);
  endtask

  task automatic exp_resp(input logic err, input logic [31:0] rd, input int stalls);
    resp_t r;
    r.err = err; r.rd = rd; r.stalls = stalls;
    resp_q.push_back(r);
  endtask

  // Core side: present the request, hold it while stalled, drop it after the commit cycle.
  task automatic run(input logic we, input logic re, input logic [2:0] t, input logic [31:0] a,
                     input logic [31:0] wd, input int gdly, input int rdly, input logic [31:0] rdata);
    int k;
    slv_gnt_dly = gdly; slv_rv_dly = rdly; slv_rdata = rdata;
    @(posedge clk); #1;
    W_en = we; R_en = re; RW_type = t; ram_addr = a; Wr_mem_data = wd;
    k = 0;
    @(negedge clk);
    while (stall && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (stall) begin
      n_checks++; n_fail++;
      $display("FAIL run_bound: stall still 1 after %0d cycles, required 0", k);
    end
    @(posedge clk); #1;
    W_en = 1'b0; R_en = 1'b0;
  endtask

  initial begin : slave
    int wait_cnt;
    int rd_pend;
    wait_cnt = 0;
    rd_pend = -1;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (rd_pend == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata = slv_rdata;
        rd_pend = -1;
      end else if (rd_pend > 0) begin
        rd_pend--;
      end
      if (!rst && bus_req) begin
        if (slv_gnt_dly >= 0 && wait_cnt == slv_gnt_dly) begin
          bus_gnt = 1'b1;
          wait_cnt = 0;
          if (!bus_we) rd_pend = slv_rv_dly;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    int   scnt;
    logic prev_req;
    req_t cur;
    resp_t r;
    scnt = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0;
        prev_req = 1'b0;
        continue;
      end
      if (bus_req && !prev_req) begin
        if (req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got addr 0x%08h, required no request", bus_addr);
        end else begin
          cur = req_q.pop_front();
          check("req_we", 32'(bus_we), 32'(cur.we));
          check("req_addr", bus_addr, cur.addr);
          check("req_wdata", bus_wdata, cur.wdata);
          check("req_be", 32'(bus_be), 32'(cur.be));
        end
      end else if (bus_req) begin
        check("req_addr_stable", bus_addr, cur.addr);
        check("req_be_stable", 32'(bus_be), 32'(cur.be));
      end
      prev_req = bus_req;
      if (stall) begin
        scnt++;
      end else if (scnt > 0) begin
        if (resp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_commit: got commit after %0d stalls, required none", scnt);
        end else begin
          r = resp_q.pop_front();
          check("resp_err", 32'(bus_err), 32'(r.err));
          check("resp_rd", Rd_mem_data, r.rd);
          check("resp_stalls", 32'(scnt), 32'(r.stalls));
        end
        scnt = 0;
      end else begin
        check("idle_err", 32'(bus_err), 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    @(negedge clk);
    check("rst_req", 32'(bus_req), 32'h0);
    check("rst_we", 32'(bus_we), 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    check("rst_be", 32'(bus_be), 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rd", Rd_mem_data, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    exp_req(1'b1, 32'h1000, 32'hA5A5A5A5, 4'b1000); exp_resp(1'b0, 32'h0, 2);
    run(1'b1, 1'b0, RW_B, 32'h1003, 32'h000000A5, 0, 0, 32'h0);

    exp_req(1'b0, 32'h2000, 32'h0, 4'b0010); exp_resp(1'b0, 32'hFFFFFFF0, 3);
    run(1'b0, 1'b1, RW_B, 32'h2001, 32'h0, 0, 0, 32'h0000F000);
    exp_req(1'b0, 32'h2000, 32'h0, 4'b0010); exp_resp(1'b0, 32'h000000F0, 3);
    run(1'b0, 1'b1, RW_BU, 32'h2001, 32'h0, 0, 0, 32'h0000F000);

    exp_req(1'b0, 32'h2000, 32'h0, 4'b1100); exp_resp(1'b0, 32'hFFFF8000, 3);
    run(1'b0, 1'b1, RW_H, 32'h2002, 32'h0, 0, 0, 32'h80001234);
    exp_req(1'b0, 32'h2000, 32'h0, 4'b1100); exp_resp(1'b0, 32'h00008000, 3);
    run(1'b0, 1'b1, RW_HU, 32'h2002, 32'h0, 0, 0, 32'h80001234);
    exp_req(1'b0, 32'h2000, 32'h0, 4'b1111); exp_resp(1'b0, 32'h80001234, 3);
    run(1'b0, 1'b1, RW_W, 32'h2000, 32'h0, 0, 0, 32'h80001234);

    exp_req(1'b1, 32'h2000, 32'hBEEFBEEF, 4'b1100); exp_resp(1'b0, 32'h80001234, 5);
    run(1'b1, 1'b0, RW_H, 32'h2002, 32'h0000BEEF, 3, 0, 32'h0);
    exp_req(1'b1, 32'h2004, 32'h3C3C3C3C, 4'b0100); exp_resp(1'b0, 32'h80001234, 2);
    run(1'b1, 1'b1, RW_B, 32'h2006, 32'h1234563C, 0, 0, 32'h0);
    exp_req(1'b0, 32'h2008, 32'h0, 4'b1111); exp_resp(1'b0, 32'h0BADF00D, 6);
    run(1'b0, 1'b1, RW_W, 32'h2008, 32'h0, 1, 2, 32'h0BADF00D);
    exp_req(1'b0, 32'h200C, 32'h0, 4'b1111); exp_resp(1'b0, 32'h11223344, 3);
    run(1'b0, 1'b1, 3'b011, 32'h200C, 32'h0, 0, 0, 32'h11223344);

`ifdef LSU_MISALIGN_TRAP_EN
    exp_resp(1'b1, 32'h0, 1);
    run(1'b0, 1'b1, RW_H, 32'h2003, 32'h0, 0, 0, 32'h80001234);
    exp_resp(1'b1, 32'h0, 1);
    run(1'b1, 1'b0, RW_W, 32'h3002, 32'hCAFEF00D, 0, 0, 32'h0);
`else
    exp_req(1'b0, 32'h2000, 32'h0, 4'b1100); exp_resp(1'b0, 32'hFFFF8000, 3);
    run(1'b0, 1'b1, RW_H, 32'h2003, 32'h0, 0, 0, 32'h80001234);
    exp_req(1'b1, 32'h3000, 32'hCAFEF00D, 4'b1111); exp_resp(1'b0, 32'hFFFF8000, 2);
    run(1'b1, 1'b0, RW_W, 32'h3002, 32'hCAFEF00D, 0, 0, 32'h0);
`endif

    exp_req(1'b0, 32'h2000, 32'h0, 4'b1111); exp_resp(1'b0, 32'h80001234, 3);
    run(1'b0, 1'b1, RW_W, 32'h2000, 32'h0, 0, 0, 32'h80001234);

    // Reset while waiting in RESP; the slave's delayed rvalid then lands in IDLE.
    exp_req(1'b0, 32'h5000, 32'h0, 4'b1111);
    slv_gnt_dly = 0; slv_rv_dly = 4; slv_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    R_en = 1'b1; RW_type = RW_W; ram_addr = 32'h5000;
    repeat (3) @(negedge clk);
    check("resp_stall_pre_rst", 32'(stall), 32'h1);
    #2 rst = 1'b1; R_en = 1'b0;
    #1;
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_req", 32'(bus_req), 32'h0);
    check("midrst_rd", Rd_mem_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_rd", Rd_mem_data, 32'h0);
      check("post_rst_stall", 32'(stall), 32'h0);
      check("post_rst_req", 32'(bus_req), 32'h0);
    end

    exp_req(1'b0, 32'h4000, 32'h0, 4'b1111); exp_resp(1'b1, 32'h0, 17);
    run(1'b0, 1'b1, RW_W, 32'h4000, 32'h0, -1, 0, 32'h0);

    exp_req(1'b0, 32'h2000, 32'h0, 4'b1111); exp_resp(1'b0, 32'h80001234, 3);
    run(1'b0, 1'b1, RW_W, 32'h2000, 32'h0, 0, 0, 32'h80001234);

    repeat (4) @(negedge clk);
    check("req_q_empty", 32'(req_q.size()), 32'h0);
    check("resp_q_empty", 32'(resp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
